prediction_streamer: RTL

//  Downstream of the multi-core CNN array. Detects a completed batch
//  (rising edge of all_done) and snapshots all N per-core predictions.

---
 rtl/prediction_streamer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/prediction_streamer.sv
// Snapshots N core predictions on the rising edge of all_done and streams them out, one core per beat.
// Optional feature: define ARGMAX_EN to report the largest prediction index/value after each drained batch.
module prediction_streamer #(
    parameter  int N           = 4,
    parameter  int OUTPUT_SIZE = 32,
    localparam int IDX_W       = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     all_done,
    input  logic [N*OUTPUT_SIZE-1:0] predictions,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUTPUT_SIZE-1:0]   m_data,
    output logic [IDX_W-1:0]         m_core_id,
    output logic                     m_last,
    output logic                     busy,
    output logic                     overflow,
    output logic [7:0]               batch_cnt,
    output logic                     argmax_valid,
    output logic [IDX_W-1:0]         argmax_id,
    output logic [OUTPUT_SIZE-1:0]   argmax_val
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 state_r;
    logic                   all_done_q_r;
    logic [OUTPUT_SIZE-1:0] buffer_r [N];

    logic                   start_s;
    logic                   accept_s;
    logic                   xfer_s;
    logic [IDX_W-1:0]       idx_next_s;

    // Edge detect, transfer handshake and next beat index.
    always_comb begin
        start_s    = all_done & ~all_done_q_r;
        accept_s   = start_s & (state_r == ST_IDLE);
        xfer_s     = m_valid & m_ready;
        idx_next_s = m_core_id + IDX_W'(1);
    end

    // Batch capture and stream sequencing; m_core_id doubles as the beat index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            all_done_q_r <= 1'b1;
            m_valid      <= 1'b0;
            m_data       <= {OUTPUT_SIZE{1'b0}};
            m_core_id    <= {IDX_W{1'b0}};
            m_last       <= 1'b0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            batch_cnt    <= 8'd0;
            for (int i = 0; i < N; i++) begin
                buffer_r[i] <= {OUTPUT_SIZE{1'b0}};
            end
        end else begin
            all_done_q_r <= all_done;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        for (int i = 0; i < N; i++) begin
                            buffer_r[i] <= predictions[i*OUTPUT_SIZE +: OUTPUT_SIZE];
                        end
                        state_r   <= ST_SEND;
                        m_valid   <= 1'b1;
                        busy      <= 1'b1;
                        m_data    <= predictions[0 +: OUTPUT_SIZE];
                        m_core_id <= {IDX_W{1'b0}};
                        m_last    <= (N == 1) ? 1'b1 : 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    // Any new batch edge while draining is lost, including on the final beat.
                    if (start_s) begin
                        overflow <= 1'b1;
                    end else begin
                        overflow <= overflow;
                    end
                    if (xfer_s && m_last) begin
                        state_r   <= ST_IDLE;
                        m_valid   <= 1'b0;
                        busy      <= 1'b0;
                        m_data    <= {OUTPUT_SIZE{1'b0}};
                        m_core_id <= {IDX_W{1'b0}};
                        m_last    <= 1'b0;
                        batch_cnt <= batch_cnt + 8'd1;
                    end else if (xfer_s) begin
                        m_core_id <= idx_next_s;
                        m_data    <= buffer_r[idx_next_s];
                        m_last    <= (idx_next_s == IDX_W'(N - 1)) ? 1'b1 : 1'b0;
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARGMAX_EN
    logic [OUTPUT_SIZE-1:0] run_val_r;
    logic [IDX_W-1:0]       run_id_r;
    logic [OUTPUT_SIZE-1:0] cand_val_s;
    logic [IDX_W-1:0]       cand_id_s;

    // Strictly-greater compare so ties keep the lowest core index.
    always_comb begin
        if (m_data > run_val_r) begin
            cand_val_s = m_data;
            cand_id_s  = m_core_id;
        end else begin
            cand_val_s = run_val_r;
            cand_id_s  = run_id_r;
        end
    end

    // Running maximum over transferred beats and one-cycle result pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_val_r    <= {OUTPUT_SIZE{1'b0}};
            run_id_r     <= {IDX_W{1'b0}};
            argmax_valid <= 1'b0;
            argmax_id    <= {IDX_W{1'b0}};
            argmax_val   <= {OUTPUT_SIZE{1'b0}};
        end else begin
            if (accept_s) begin
                run_val_r    <= {OUTPUT_SIZE{1'b0}};
                run_id_r     <= {IDX_W{1'b0}};
                argmax_valid <= 1'b0;
            end else if (xfer_s) begin
                run_val_r <= cand_val_s;
                run_id_r  <= cand_id_s;
                if (m_last) begin
                    argmax_valid <= 1'b1;
                    argmax_id    <= cand_id_s;
                    argmax_val   <= cand_val_s;
                end else begin
                    argmax_valid <= 1'b0;
                end
            end else begin
                argmax_valid <= 1'b0;
            end
        end
    end
`else
    assign argmax_valid = 1'b0;
    assign argmax_id    = {IDX_W{1'b0}};
    assign argmax_val   = {OUTPUT_SIZE{1'b0}};
`endif

endmodule
